// File: rtl/mips_multicycle_rtype.sv
// Multi-cycle MIPS core for R-type instructions with program-load and debug ports.
// Define MIPS_BEQ_EN to add BEQ (opcode 000100) support.
module mips_multicycle_rtype #(
  parameter int WIDTH      = 16,
  parameter int IMEM_DEPTH = 1024,
  parameter int IMEM_AW    = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_wdata,
  input  logic               dbg_we,
  input  logic [4:0]         dbg_addr,
  input  logic [WIDTH-1:0]   dbg_wdata,
  output logic [WIDTH-1:0]   dbg_rdata,
  output logic [WIDTH-1:0]   PC,
  output logic [31:0]        IR,
  output logic [WIDTH-1:0]   ALUOut,
  output logic [2:0]         state,
  output logic               halted,
  output logic [15:0]        retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] F_ADD    = 6'd32;
  localparam logic [5:0] F_SUB    = 6'd34;
  localparam logic [5:0] F_AND    = 6'd36;
  localparam logic [5:0] F_OR     = 6'd37;
  localparam logic [5:0] F_NOR    = 6'd39;
  localparam logic [5:0] F_SLT    = 6'd42;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_alu;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [31:0]        r_ir;
  logic [15:0]        r_retired;
  logic               r_halted;
  logic [31:0]        r_imem [IMEM_DEPTH];
  logic [WIDTH-1:0]   r_regs [32];

  logic [IMEM_AW-1:0] w_fetch_idx;
  logic               w_legal;
  logic               w_is_beq;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_diff;
  logic [4:0]         w_rd;
  logic               w_dbg_ok;

  assign w_fetch_idx = IMEM_AW'(r_pc >> 2);
  assign w_rd        = r_ir[15:11];
  assign w_diff      = r_a - r_b;
  assign w_dbg_ok    = dbg_we && (dbg_addr != 5'd0) &&
                       ((r_state == S_IDLE) || (r_state == S_HALT));

`ifdef MIPS_BEQ_EN
  localparam logic [5:0] OP_BEQ = 6'd4;
  logic [WIDTH-1:0] w_br_off;
  assign w_is_beq = (r_ir[31:26] == OP_BEQ);
  assign w_br_off = WIDTH'({{14{r_ir[15]}}, r_ir[15:0], 2'b00});
`else
  assign w_is_beq = 1'b0;
`endif

  // Legality of the instruction currently held in IR
  always_comb begin
    w_legal = 1'b0;
    if (r_ir[31:26] == OP_RTYPE) begin
      case (r_ir[5:0])
        F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: w_legal = 1'b1;
        default:                                 w_legal = 1'b0;
      endcase
    end else begin
      w_legal = w_is_beq;
    end
  end

  // ALU; a branch always produces A-B regardless of its low bits
  always_comb begin
    w_alu = '0;
    if (w_is_beq) begin
      w_alu = w_diff;
    end else begin
      case (r_ir[5:0])
        F_ADD:   w_alu = r_a + r_b;
        F_SUB:   w_alu = w_diff;
        F_AND:   w_alu = r_a & r_b;
        F_OR:    w_alu = r_a | r_b;
        F_NOR:   w_alu = ~(r_a | r_b);
        F_SLT:   w_alu = ($signed(r_a) < $signed(r_b)) ? WIDTH'(1) : WIDTH'(0);
        default: w_alu = '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH; else w_next = S_IDLE;
      S_FETCH:  if (imem_we) w_next = S_FETCH; else w_next = S_DECODE;
      S_DECODE: if (w_legal) w_next = S_EXEC; else w_next = S_HALT;
      S_EXEC: begin
        if (w_is_beq) w_next = run ? S_FETCH : S_IDLE;
        else          w_next = S_WB;
      end
      S_WB:     if (run) w_next = S_FETCH; else w_next = S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register and halt flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == S_HALT);
    end
  end

  // Program-load port; memory survives reset
  always_ff @(posedge clock) begin
    if (imem_we) r_imem[imem_addr] <= imem_wdata;
  end

  // PC, IR, operand latches, ALU result and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= 32'd0;
      r_alu     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_retired <= 16'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!imem_we) begin
            r_ir <= r_imem[w_fetch_idx];
            r_pc <= r_pc + PC_STEP;
          end
        end
        S_DECODE: begin
          r_a <= r_regs[r_ir[25:21]];
          r_b <= r_regs[r_ir[20:16]];
        end
        S_EXEC: begin
          r_alu <= w_alu;
`ifdef MIPS_BEQ_EN
          if (w_is_beq) begin
            r_retired <= r_retired + 16'd1;
            if (w_diff == '0) r_pc <= r_pc + w_br_off;
          end
`endif
        end
        S_WB:    r_retired <= r_retired + 16'd1;
        default: ;
      endcase
    end
  end

  // Register file: writeback has priority, debug writes only land when stopped
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WB) && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= r_alu;
    end else if (w_dbg_ok) begin
      r_regs[dbg_addr] <= dbg_wdata;
    end
  end

  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];
  assign PC        = r_pc;
  assign IR        = r_ir;
  assign ALUOut    = r_alu;
  assign state     = r_state;
  assign halted    = r_halted;
  assign retired   = r_retired;

endmodule

// File: tb/tb_mips_multicycle_rtype.sv
// Self-checking bench for mips_multicycle_rtype (WIDTH=16) against a behavioural program model.
module tb_mips_multicycle_rtype;
  localparam int WIDTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_addr = 10'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [15:0] dbg_wdata = 16'd0;
  logic [15:0] dbg_rdata, PC, ALUOut, retired;
  logic [31:0] IR;
  logic [2:0]  state;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_regs [32];
  logic [31:0] prog [$];

  mips_multicycle_rtype #(.WIDTH(WIDTH), .IMEM_DEPTH(1024), .IMEM_AW(10)) dut (
    .clock(clock), .reset(reset), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .PC(PC), .IR(IR), .ALUOut(ALUOut), .state(state),
    .halted(halted), .retired(retired)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [15:0] ref_alu(input logic [5:0] f, input logic [15:0] a,
                                          input logic [15:0] b);
    int sa, sb;
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    case (f)
      6'd32:   return 16'((int'(a) + int'(b)) % 65536);
      6'd34:   return 16'((int'(a) - int'(b) + 65536) % 65536);
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd39:   return ~(a | b);
      6'd42:   return (sa < sb) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; imem_we = 1'b0; dbg_we = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 16'd0;
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      imem_addr = 10'(i); imem_wdata = prog[i]; imem_we = 1'b1;
      tick();
    end
    imem_we = 1'b0;
  endtask

  task automatic dbg_write(input logic [4:0] idx, input logic [15:0] v);
    dbg_addr = idx; dbg_wdata = v; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
    if (idx != 5'd0) m_regs[idx] = v;
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [15:0] v);
    dbg_addr = idx;
    #1;
    v = dbg_rdata;
  endtask

  task automatic run_to_halt(input int bound, output int cycles);
    run = 1'b1; cycles = 0;
    while (halted !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  // Executes prog on m_regs until the first illegal word
  task automatic model_run(output int n_ret, output logic [15:0] last, output logic [15:0] fpc);
    logic done;
    logic [15:0] r;
    n_ret = 0; last = 16'd0; fpc = 16'd0; done = 1'b0;
    foreach (prog[i]) begin
      if (!done) begin
        if (prog[i][31:26] == 6'd0 && (prog[i][5:0] inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42})) begin
          r = ref_alu(prog[i][5:0], m_regs[prog[i][25:21]], m_regs[prog[i][20:16]]);
          if (prog[i][15:11] != 5'd0) m_regs[prog[i][15:11]] = r;
          last = r;
          n_ret++;
        end else begin
          fpc = 16'((i + 1) * 4);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    n_tests++;
    if (PC !== 16'd0 || IR !== 32'd0 || ALUOut !== 16'd0 || state !== 3'd0 ||
        halted !== 1'b0 || retired !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: PC=%h IR=%h ALUOut=%h state=%0d halted=%b retired=%0d, required all zero",
               PC, IR, ALUOut, state, halted, retired);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      n_tests++;
      if (v !== 16'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h required 0000", i, v); end
    end
  endtask

  task automatic test_alu_ops();
    logic [15:0] v;
    logic [15:0] exp_v [5] = '{16'h0FFF, 16'h0000, 16'h0FFF, 16'hF000, 16'h0E1F};
    int cyc;
    do_reset();
    prog = {rtype(1, 2, 3, 6'd32), rtype(1, 2, 4, 6'd36), rtype(1, 2, 5, 6'd37),
            rtype(1, 2, 6, 6'd39), rtype(2, 1, 7, 6'd34), 32'd0};
    load_prog();
    dbg_write(5'd1, 16'h00F0);
    dbg_write(5'd2, 16'h0F0F);
    run = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      repeat (4) tick();
      n_tests++;
      if (retired !== 16'(k) || state !== 3'd1) begin
        n_fail++;
        $display("FAIL alu_latency_%0d: retired=%0d state=%0d, required retired=%0d state=1", k, retired, state, k);
      end
    end
    run_to_halt(10, cyc);
    n_tests++;
    if (halted !== 1'b1 || state !== 3'd5 || PC !== 16'h0018) begin
      n_fail++;
      $display("FAIL alu_halt: halted=%b state=%0d PC=%h, required 1 5 0018", halted, state, PC);
    end
    for (int i = 0; i < 5; i++) begin
      read_reg(5'(i + 3), v);
      n_tests++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL alu_R%0d: got %h required %h", i + 3, v, exp_v[i]); end
    end
  endtask

  task automatic test_slt_wrap();
    logic [15:0] v;
    logic [15:0] exp_v [3] = '{16'h0001, 16'h0000, 16'h0000};
    int cyc;
    do_reset();
    prog = {rtype(1, 2, 3, 6'd42), rtype(2, 1, 4, 6'd42), rtype(1, 1, 5, 6'd32), 32'd0};
    load_prog();
    dbg_write(5'd1, 16'h8000);
    dbg_write(5'd2, 16'h0001);
    run_to_halt(40, cyc);
    for (int i = 0; i < 3; i++) begin
      read_reg(5'(i + 3), v);
      n_tests++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL slt_R%0d: got %h required %h", i + 3, v, exp_v[i]); end
    end
  endtask

  task automatic test_r0();
    logic [15:0] v;
    int cyc;
    do_reset();
    prog = {rtype(1, 2, 0, 6'd32), 32'd0};
    load_prog();
    dbg_write(5'd1, 16'd5);
    dbg_write(5'd2, 16'd5);
    dbg_write(5'd0, 16'h7777);
    run_to_halt(20, cyc);
    read_reg(5'd0, v);
    n_tests++;
    if (v !== 16'd0 || ALUOut !== 16'h000A || retired !== 16'd1 || cyc !== 7) begin
      n_fail++;
      $display("FAIL r0_protect: R0=%h ALUOut=%h retired=%0d cycles=%0d, required 0000 000A 1 7", v, ALUOut, retired, cyc);
    end
  endtask

  task automatic test_halt_illegal();
    logic [15:0] v, last, fpc;
    int cyc, n_ret;
    do_reset();
    prog = {rtype(1, 2, 3, 6'd32), rtype(1, 2, 4, 6'd37), 32'h8C010000};
    load_prog();
    dbg_write(5'd1, 16'h1234);
    dbg_write(5'd2, 16'h0F0F);
    model_run(n_ret, last, fpc);
    run_to_halt(30, cyc);
    n_tests++;
    if (halted !== 1'b1 || state !== 3'd5 || PC !== fpc || IR !== 32'h8C010000 || retired !== 16'(n_ret)) begin
      n_fail++;
      $display("FAIL illegal_halt: halted=%b state=%0d PC=%h IR=%h retired=%0d, required 1 5 %h 8C010000 %0d",
               halted, state, PC, IR, retired, fpc, n_ret);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      n_tests++;
      if (v !== m_regs[i]) begin n_fail++; $display("FAIL illegal_R%0d: got %h required %h", i, v, m_regs[i]); end
    end
    repeat (5) tick();
    n_tests++;
    if (state !== 3'd5 || PC !== 16'h000C) begin
      n_fail++;
      $display("FAIL halt_sticky: state=%0d PC=%h, required 5 000C", state, PC);
    end
    dbg_write(5'd9, 16'hBEEF);
    read_reg(5'd9, v);
    n_tests++;
    if (v !== 16'hBEEF) begin n_fail++; $display("FAIL halt_dbg_write: got %h required BEEF", v); end
  endtask

  task automatic test_stall_rundrop();
    logic [15:0] v;
    logic [31:0] new_word;
    new_word = rtype(1, 2, 3, 6'd37);
    do_reset();
    prog = {rtype(1, 2, 3, 6'd32), 32'd0};
    load_prog();
    dbg_write(5'd1, 16'h00F0);
    dbg_write(5'd2, 16'h0F0F);
    run = 1'b1;
    tick();
    imem_addr = 10'd0; imem_wdata = new_word; imem_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (PC !== 16'd0 || state !== 3'd1) begin
        n_fail++;
        $display("FAIL stall_%0d: PC=%h state=%0d, required 0000 1", i, PC, state);
      end
    end
    imem_we = 1'b0;
    dbg_addr = 5'd8; dbg_wdata = 16'h1234; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
    n_tests++;
    if (IR !== new_word || PC !== 16'd4 || state !== 3'd2) begin
      n_fail++;
      $display("FAIL stall_release: IR=%h PC=%h state=%0d, required %h 0004 2", IR, PC, state, new_word);
    end
    tick();
    run = 1'b0;
    tick();
    tick();
    n_tests++;
    if (state !== 3'd0 || retired !== 16'd1) begin
      n_fail++;
      $display("FAIL run_drop: state=%0d retired=%0d, required 0 1", state, retired);
    end
    read_reg(5'd3, v);
    n_tests++;
    if (v !== 16'h0FFF) begin n_fail++; $display("FAIL stall_new_word_R3: got %h required 0FFF", v); end
    read_reg(5'd8, v);
    n_tests++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL dbg_ignored_running: got %h required 0000", v); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    do_reset();
    prog = {rtype(1, 2, 3, 6'd32), 32'd0};
    load_prog();
    dbg_write(5'd1, 16'h0003);
    dbg_write(5'd2, 16'h0004);
    run = 1'b1;
    repeat (4) tick();
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0;
    read_reg(5'd3, v);
    n_tests++;
    if (state !== 3'd0 || retired !== 16'd0 || PC !== 16'd0 || v !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: state=%0d retired=%0d PC=%h R3=%h, required 0 0 0000 0000", state, retired, PC, v);
    end
  endtask

  task automatic test_random();
    logic [5:0] functs [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    logic [15:0] v, last, fpc;
    int cyc, n_ret, n;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      n = 8 + round * 3;
      for (int r = 1; r < 8; r++) dbg_write(5'(r), 16'($urandom));
      prog.delete();
      for (int i = 0; i < n; i++)
        prog.push_back(rtype(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), functs[$urandom_range(0, 5)]));
      prog.push_back(32'd0);
      load_prog();
      model_run(n_ret, last, fpc);
      run_to_halt(4 * n + 20, cyc);
      n_tests++;
      if (halted !== 1'b1 || cyc !== 4 * n + 3 || retired !== 16'(n_ret) || PC !== fpc || ALUOut !== last) begin
        n_fail++;
        $display("FAIL random%0d_status: halted=%b cycles=%0d retired=%0d PC=%h ALUOut=%h, required 1 %0d %0d %h %h",
                 round, halted, cyc, retired, PC, ALUOut, 4 * n + 3, n_ret, fpc, last);
      end
      for (int i = 0; i < 8; i++) begin
        read_reg(5'(i), v);
        n_tests++;
        if (v !== m_regs[i]) begin n_fail++; $display("FAIL random%0d_R%0d: got %h required %h", round, i, v, m_regs[i]); end
      end
    end
  endtask

  task automatic test_beq();
    logic [31:0] beq_word;
    int cyc;
    beq_word = {6'b000100, 5'd1, 5'd1, 16'hFFFE};
    do_reset();
    prog = {rtype(1, 2, 3, 6'd32), rtype(1, 2, 4, 6'd32), beq_word, 32'd0};
    load_prog();
    dbg_write(5'd1, 16'h0011);
    dbg_write(5'd2, 16'h0022);
`ifdef MIPS_BEQ_EN
    run = 1'b1;
    tick();
    repeat (11) tick();
    cyc = 0;
    n_tests++;
    if (PC !== 16'h0004 || state !== 3'd1 || retired !== 16'd3 || ALUOut !== 16'd0) begin
      n_fail++;
      $display("FAIL beq_taken: PC=%h state=%0d retired=%0d ALUOut=%h, required 0004 1 3 0000", PC, state, retired, ALUOut);
    end
`else
    run_to_halt(40, cyc);
    n_tests++;
    if (halted !== 1'b1 || PC !== 16'h000C || IR !== beq_word || retired !== 16'd2) begin
      n_fail++;
      $display("FAIL beq_disabled: halted=%b PC=%h IR=%h retired=%0d, required 1 000C %h 2", halted, PC, IR, retired, beq_word);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_slt_wrap();
    test_r0();
    test_halt_illegal();
    test_stall_rundrop();
    test_reset_mid();
    test_random();
    test_beq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
